// File: rtl/gs_ddram_pkg.sv
// Shared types and byte-lane helpers for the GS DDR3 arbiter.
package gs_ddram_pkg;

    localparam int REQ_AW = 32;

    typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;

    typedef struct packed {
        logic [REQ_AW-1:0] addr;
        logic [7:0]        din;
        logic              we;
    } req_t;

    function automatic logic [7:0] be_of(input logic [2:0] lo);
        return 8'b1 << lo;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [63:0] line, input logic [2:0] lo);
        return line[{lo, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gs_ddram_port.sv
// One requester slot: byte request latch and ready handshake. With
// GS_DDRAM_LINE_CACHE_EN defined it also keeps a one-line write-through read cache.
module gs_ddram_port
    import gs_ddram_pkg::*;
#(
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    input  logic              rd,
    input  logic              we,
    output logic [7:0]        dout,
    output logic              ready,
    output logic              pend,
    output logic [ADDR_W-4:0] word,
    output logic [2:0]        lo,
    output logic [7:0]        wdata,
    output logic              is_we,
    input  logic              done,
    input  logic [63:0]       line_in,
    input  logic              snoop_we,
    input  logic [ADDR_W-4:0] snoop_word,
    input  logic [2:0]        snoop_lo,
    input  logic [7:0]        snoop_din
);
    req_t       req;
    logic       strobe;
    logic       hit;
    logic [7:0] hit_byte;
    logic       unused_hi;

    assign strobe    = ready && (rd || we);
    assign word      = req.addr[ADDR_W-1:3];
    assign lo        = req.addr[2:0];
    assign wdata     = req.din;
    assign is_we     = req.we;
    assign unused_hi = ^req.addr;

`ifdef GS_DDRAM_LINE_CACHE_EN
    logic [63:0]       cline;
    logic [ADDR_W-4:0] tag;
    logic              line_vld;

    assign hit      = strobe && !we && line_vld && (tag == addr[ADDR_W-1:3]);
    assign hit_byte = byte_sel(cline, addr[2:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            line_vld <= 1'b0;
        else if (done && !req.we)
            line_vld <= 1'b1;
    end

    // Own misses refill the line; any completed write to the cached word patches its byte.
    always_ff @(posedge clk) begin
        if (done && !req.we) begin
            cline <= line_in;
            tag   <= word;
        end else if (snoop_we && line_vld && (tag == snoop_word)) begin
            cline[{snoop_lo, 3'b000} +: 8] <= snoop_din;
        end
    end
`else
    logic unused_cache;
    assign hit          = 1'b0;
    assign hit_byte     = 8'h00;
    assign unused_cache = ^{snoop_we, snoop_word, snoop_lo, snoop_din};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b1;
            pend  <= 1'b0;
            dout  <= 8'h00;
        end else if (done) begin
            ready <= 1'b1;
            pend  <= 1'b0;
            if (!req.we)
                dout <= byte_sel(line_in, req.addr[2:0]);
        end else if (hit) begin
            dout <= hit_byte;
        end else if (strobe) begin
            ready <= 1'b0;
            pend  <= 1'b1;
        end
    end

    // A simultaneous rd+we is captured as a write.
    always_ff @(posedge clk) begin
        if (strobe && !hit)
            req <= '{addr: REQ_AW'(addr), din: din, we: we};
    end

endmodule

// File: rtl/gs_ddram_arbiter.sv
// GS DDR3 arbiter: two byte ports share one 64-bit DDRAM port, round-robin.
// Define GS_DDRAM_LINE_CACHE_EN for a one-line read cache per port.
module gs_ddram_arbiter
    import gs_ddram_pkg::*;
#(
    parameter int          ADDR_W    = 21,
    parameter logic [28:0] BASE_ADDR = 29'h0300000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_din,
    input  logic              a_rd,
    input  logic              a_we,
    output logic [7:0]        a_dout,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_din,
    input  logic              b_rd,
    input  logic              b_we,
    output logic [7:0]        b_dout,
    output logic              b_ready,
    input  logic              DDRAM_BUSY,
    output logic [28:0]       DDRAM_ADDR,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic              DDRAM_RD,
    output logic              DDRAM_WE,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY
);
    state_t            state;
    logic              gnt;
    logic              rr;
    logic              pend_a, pend_b, we_a, we_b, done_a, done_b;
    logic [ADDR_W-4:0] word_a, word_b, sel_word, snoop_word;
    logic [2:0]        lo_a, lo_b, sel_lo, snoop_lo;
    logic [7:0]        wd_a, wd_b, sel_din, snoop_din;
    logic              pick_b, sel_we, wr_fin, rd_fin;

    assign DDRAM_BURSTCNT = 8'd1;

    assign wr_fin = (state == WR) && !DDRAM_BUSY;
    assign rd_fin = (state == RWAIT) && DDRAM_DOUT_READY;
    assign done_a = (wr_fin || rd_fin) && !gnt;
    assign done_b = (wr_fin || rd_fin) && gnt;

    // rr names the port that wins when both are pending.
    always_comb begin
        pick_b     = (pend_a && pend_b) ? rr : pend_b;
        sel_word   = pick_b ? word_b : word_a;
        sel_lo     = pick_b ? lo_b : lo_a;
        sel_din    = pick_b ? wd_b : wd_a;
        sel_we     = pick_b ? we_b : we_a;
        snoop_word = gnt ? word_b : word_a;
        snoop_lo   = gnt ? lo_b : lo_a;
        snoop_din  = gnt ? wd_b : wd_a;
    end

    gs_ddram_port #(.ADDR_W(ADDR_W)) u_port_a (
        .clk(clk_sys), .reset(reset),
        .addr(a_addr), .din(a_din), .rd(a_rd), .we(a_we),
        .dout(a_dout), .ready(a_ready), .pend(pend_a),
        .word(word_a), .lo(lo_a), .wdata(wd_a), .is_we(we_a),
        .done(done_a), .line_in(DDRAM_DOUT),
        .snoop_we(wr_fin), .snoop_word(snoop_word), .snoop_lo(snoop_lo), .snoop_din(snoop_din)
    );

    gs_ddram_port #(.ADDR_W(ADDR_W)) u_port_b (
        .clk(clk_sys), .reset(reset),
        .addr(b_addr), .din(b_din), .rd(b_rd), .we(b_we),
        .dout(b_dout), .ready(b_ready), .pend(pend_b),
        .word(word_b), .lo(lo_b), .wdata(wd_b), .is_we(we_b),
        .done(done_b), .line_in(DDRAM_DOUT),
        .snoop_we(wr_fin), .snoop_word(snoop_word), .snoop_lo(snoop_lo), .snoop_din(snoop_din)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            rr         <= 1'b0;
            DDRAM_RD   <= 1'b0;
            DDRAM_WE   <= 1'b0;
            DDRAM_ADDR <= '0;
            DDRAM_BE   <= '0;
            DDRAM_DIN  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_a || pend_b) begin
                        gnt <= pick_b;
                        if (pend_a && pend_b)
                            rr <= ~rr;
                        DDRAM_ADDR <= BASE_ADDR + 29'(sel_word);
                        DDRAM_BE   <= be_of(sel_lo);
                        DDRAM_DIN  <= {8{sel_din}};
                        if (sel_we) begin
                            DDRAM_WE <= 1'b1;
                            state    <= WR;
                        end else begin
                            DDRAM_RD <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (DDRAM_DOUT_READY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_ddram_arbiter.sv
// Bench for gs_ddram_arbiter: directed scenarios, then random traffic on both
// ports against a byte-memory model and an emulated DDR3 port.
`timescale 1ns/1ps
module tb_gs_ddram_arbiter;
    localparam logic [28:0] BASE = 29'h0300000;
    localparam int NOPS = 150;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [20:0] a_addr, b_addr;
    logic [7:0]  a_din, b_din, a_dout, b_dout;
    logic        a_rd, a_we, b_rd, b_we, a_ready, b_ready;
    logic        DDRAM_BUSY, DDRAM_RD, DDRAM_WE, DDRAM_DOUT_READY;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
    logic [63:0] DDRAM_DIN, DDRAM_DOUT;

    gs_ddram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_addr(a_addr), .a_din(a_din), .a_rd(a_rd), .a_we(a_we), .a_dout(a_dout), .a_ready(a_ready),
        .b_addr(b_addr), .b_din(b_din), .b_rd(b_rd), .b_we(b_we), .b_dout(b_dout), .b_ready(b_ready),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk_sys);
    endtask

    // Memory model: DDR word store plus a byte-addressed reference view.
    logic [63:0] ddr_mem [int];
    logic [7:0]  ref_mem [int];

    function automatic logic [7:0] init_byte(input logic [28:0] w, input logic [2:0] lane);
        return w[7:0] ^ w[15:8] ^ {lane, 5'b10101};
    endfunction

    function automatic logic [63:0] ddr_get(input logic [28:0] w);
        logic [63:0] v;
        if (ddr_mem.exists(int'(w)))
            return ddr_mem[int'(w)];
        for (int l = 0; l < 8; l++)
            v[8*l +: 8] = init_byte(w, 3'(l));
        return v;
    endfunction

    function automatic logic [7:0] ref_get(input logic [20:0] a);
        if (ref_mem.exists(int'(a)))
            return ref_mem[int'(a)];
        return init_byte(BASE + 29'(a[20:3]), a[2:0]);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int l = 0; l < 8; l++)
            if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
        return r;
    endfunction

    // Random-phase state per port (0=A, 1=B).
    bit          pw [2];
    bit          prd [2];
    logic [7:0]  pexp [2];
    int          pt [2];
    int          ops [2];
    bit          oc_v [2];
    bit          oc_we [2];
    logic [28:0] oc_w [2];
    logic [7:0]  oc_be [2];
    logic [7:0]  oc_din [2];
    int          resp_cnt = 0;
    logic [63:0] resp_data;

    task automatic ddr_step();
        int m;
        int p;
        DDRAM_DOUT_READY = 1'b0;
        DDRAM_DOUT = {$urandom, $urandom};
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                DDRAM_DOUT = resp_data;
                DDRAM_DOUT_READY = 1'b1;
            end
        end
        DDRAM_BUSY = ($urandom_range(0, 3) == 0);
        if ((DDRAM_WE || DDRAM_RD) && !DDRAM_BUSY) begin
            m = 0;
            p = 0;
            for (int q = 0; q < 2; q++)
                if (oc_v[q] && oc_w[q] == DDRAM_ADDR) begin
                    m++;
                    p = q;
                end
            check_val("cmd_match", m, 1);
            if (m == 1) begin
                check_val("cmd_ctl", {DDRAM_WE, DDRAM_RD, DDRAM_BE}, {oc_we[p], !oc_we[p], oc_be[p]});
                if (oc_we[p])
                    check_val("cmd_din", DDRAM_DIN, {8{oc_din[p]}});
                oc_v[p] = 1'b0;
            end
            if (DDRAM_WE) begin
                ddr_mem[int'(DDRAM_ADDR)] = merge(ddr_get(DDRAM_ADDR), DDRAM_DIN, DDRAM_BE);
            end else begin
                resp_data = ddr_get(DDRAM_ADDR);
                resp_cnt  = $urandom_range(1, 4);
            end
        end
    endtask

    task automatic port_step(input int p);
        logic        rdy;
        logic [7:0]  dv;
        logic [20:0] ad;
        logic [7:0]  d;
        int          kind;
        rdy = (p == 0) ? a_ready : b_ready;
        dv  = (p == 0) ? a_dout : b_dout;
        if (pw[p]) begin
            if (rdy) begin
                pw[p] = 1'b0;
                if (prd[p])
                    check_val($sformatf("rnd_rd_port%0d", p), dv, pexp[p]);
            end else begin
                pt[p]++;
                if (pt[p] > 400) begin
                    check_val($sformatf("rnd_timeout_port%0d", p), pt[p], 0);
                    pw[p] = 1'b0;
                end
            end
        end
        if (!pw[p] && ops[p] < NOPS && $urandom_range(0, 2) == 0) begin
            ad = 21'($urandom_range(0, 63));
            ad[20] = (p == 1);
            d = 8'($urandom);
            kind = $urandom_range(0, 4);
            if (p == 0) begin
                a_addr = ad; a_din = d; a_rd = (kind < 2 || kind == 4); a_we = (kind >= 2);
            end else begin
                b_addr = ad; b_din = d; b_rd = (kind < 2 || kind == 4); b_we = (kind >= 2);
            end
            if (kind >= 2) begin
                ref_mem[int'(ad)] = d;
                prd[p] = 1'b0;
            end else begin
                prd[p] = 1'b1;
                pexp[p] = ref_get(ad);
            end
            oc_v[p]   = 1'b1;
            oc_we[p]  = (kind >= 2);
            oc_w[p]   = BASE + 29'(ad[20:3]);
            oc_be[p]  = 8'h01 << ad[2:0];
            oc_din[p] = d;
            pw[p] = 1'b1;
            pt[p] = 0;
            ops[p]++;
        end
    endtask

    task automatic wait_ready(input int p, input string tag);
        int i;
        for (i = 0; i < 100; i++) begin
            if ((p == 0) ? a_ready : b_ready) break;
            nclk();
        end
        if (i == 100) check_val(tag, i, 0);
    endtask

    task automatic write_pair(output logic [28:0] first, output logic [28:0] second);
        int seen;
        seen = 0;
        first = 'x;
        second = 'x;
        a_addr = 21'h10; a_din = 8'h11; a_we = 1'b1;
        b_addr = 21'h20; b_din = 8'h22; b_we = 1'b1;
        nclk();
        a_we = 1'b0; b_we = 1'b0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            nclk();
            if (DDRAM_WE) begin
                if (seen == 0) first = DDRAM_ADDR;
                else second = DDRAM_ADDR;
                seen++;
            end
        end
        wait_ready(0, "pair_a_timeout");
        wait_ready(1, "pair_b_timeout");
    endtask

    initial begin
        int rd_cycles;
        logic [28:0] f, s;
        bit fin;
        logic rd_seen;

        reset = 1'b1;
        a_addr = '0; a_din = '0; a_rd = 1'b0; a_we = 1'b0;
        b_addr = '0; b_din = '0; b_rd = 1'b0; b_we = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        nclk();
        nclk();
        check_val("rst_ready", {a_ready, b_ready}, 2'b11);
        check_val("rst_dout", {a_dout, b_dout}, 16'h0000);
        check_val("rst_rdwe", {DDRAM_RD, DDRAM_WE}, 2'b00);
        check_val("rst_addr_be", {DDRAM_ADDR, DDRAM_BE}, 37'h0);
        check_val("rst_din", DDRAM_DIN, 64'h0);
        check_val("burstcnt", DDRAM_BURSTCNT, 8'd1);
        reset = 1'b0;
        nclk();

        // Single write, no wait states.
        a_addr = 21'h00005; a_din = 8'h5A; a_we = 1'b1;
        nclk();
        a_we = 1'b0;
        check_val("wr_ready_drop", a_ready, 1'b0);
        nclk();
        check_val("wr_we", DDRAM_WE, 1'b1);
        check_val("wr_addr", DDRAM_ADDR, 29'h0300000);
        check_val("wr_be", DDRAM_BE, 8'h20);
        check_val("wr_din", DDRAM_DIN, 64'h5A5A5A5A5A5A5A5A);
        nclk();
        check_val("wr_ready_3cyc", a_ready, 1'b1);
        check_val("wr_we_drop", DDRAM_WE, 1'b0);

        // Read with four busy cycles.
        a_addr = 21'h00001; a_rd = 1'b1; DDRAM_BUSY = 1'b1;
        nclk();
        a_rd = 1'b0;
        rd_cycles = 0;
        for (int i = 0; i < 30 && !(rd_cycles > 0 && !DDRAM_RD); i++) begin
            nclk();
            if (DDRAM_RD) begin
                rd_cycles++;
                if (rd_cycles == 5) DDRAM_BUSY = 1'b0;
            end
        end
        check_val("rd_held", rd_cycles, 5);
        check_val("rd_wait_ready", a_ready, 1'b0);
        DDRAM_DOUT = 64'h0011223344556677; DDRAM_DOUT_READY = 1'b1;
        nclk();
        DDRAM_DOUT_READY = 1'b0;
        check_val("rd_dout", a_dout, 8'h66);
        check_val("rd_ready", a_ready, 1'b1);

        // Simultaneous pairs alternate priority.
        write_pair(f, s);
        check_val("rr1_first", f, BASE + 29'h2);
        check_val("rr1_second", s, BASE + 29'h4);
        write_pair(f, s);
        check_val("rr2_first", f, BASE + 29'h4);
        check_val("rr2_second", s, BASE + 29'h2);

        // B arrives while A read is outstanding.
        a_addr = 21'h00008; a_rd = 1'b1;
        nclk();
        a_rd = 1'b0;
        nclk();
        check_val("pend_a_rd", DDRAM_RD, 1'b1);
        nclk();
        b_addr = 21'h00030; b_din = 8'h77; b_we = 1'b1;
        nclk();
        b_we = 1'b0;
        repeat (2) begin
            check_val("pend_b_hold", {b_ready, DDRAM_WE}, 2'b00);
            nclk();
        end
        DDRAM_DOUT = 64'hA1B2C3D4E5F60718; DDRAM_DOUT_READY = 1'b1;
        nclk();
        DDRAM_DOUT_READY = 1'b0;
        check_val("pend_a_dout", {a_ready, a_dout}, {1'b1, 8'h18});
        check_val("pend_b_still", b_ready, 1'b0);
        nclk();
        check_val("pend_b_issue", {DDRAM_WE, DDRAM_ADDR}, {1'b1, BASE + 29'h6});
        check_val("pend_b_notyet", b_ready, 1'b0);
        nclk();
        check_val("pend_b_done", b_ready, 1'b1);

        // Reset in RWAIT, then a stray DOUT_READY.
        a_addr = 21'h00042; a_rd = 1'b1;
        nclk();
        a_rd = 1'b0;
        nclk();
        nclk();
        check_val("rst_rwait_pre", {a_ready, DDRAM_RD}, 2'b00);
        reset = 1'b1;
        #1;
        check_val("rst_async", {a_ready, DDRAM_RD, a_dout}, {1'b1, 1'b0, 8'h00});
        nclk();
        reset = 1'b0;
        DDRAM_DOUT = 64'hFFFFFFFFFFFFFFFF; DDRAM_DOUT_READY = 1'b1;
        nclk();
        DDRAM_DOUT_READY = 1'b0;
        nclk();
        check_val("rst_stray", {a_dout, a_ready, DDRAM_RD, DDRAM_WE}, {8'h00, 1'b1, 1'b0, 1'b0});

`ifdef GS_DDRAM_LINE_CACHE_EN
        // Miss fill, foreign write-through, then a hit with no DDR read.
        a_addr = 21'h00100; a_rd = 1'b1;
        nclk();
        a_rd = 1'b0;
        for (int i = 0; i < 20 && !DDRAM_RD; i++) nclk();
        check_val("cache_miss_rd", DDRAM_RD, 1'b1);
        nclk();
        DDRAM_DOUT = 64'h0706050403020100; DDRAM_DOUT_READY = 1'b1;
        nclk();
        DDRAM_DOUT_READY = 1'b0;
        check_val("cache_miss_dout", a_dout, 8'h00);
        b_addr = 21'h00103; b_din = 8'hEE; b_we = 1'b1;
        nclk();
        b_we = 1'b0;
        wait_ready(1, "cache_b_timeout");
        nclk();
        a_addr = 21'h00103; a_rd = 1'b1;
        nclk();
        a_rd = 1'b0;
        check_val("cache_hit", {a_ready, a_dout}, {1'b1, 8'hEE});
        rd_seen = DDRAM_RD;
        repeat (4) begin
            nclk();
            rd_seen = rd_seen | DDRAM_RD;
        end
        check_val("cache_no_rd", rd_seen, 1'b0);
`endif

        // Random traffic, A in the low half, B in the high half.
        for (int p = 0; p < 2; p++) begin
            pw[p] = 1'b0; ops[p] = 0; oc_v[p] = 1'b0; pt[p] = 0;
        end
        fin = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            nclk();
            a_rd = 1'b0; a_we = 1'b0; b_rd = 1'b0; b_we = 1'b0;
            ddr_step();
            port_step(0);
            port_step(1);
            if (ops[0] >= NOPS && ops[1] >= NOPS && !pw[0] && !pw[1] && resp_cnt == 0)
                fin = 1'b1;
        end
        a_rd = 1'b0; a_we = 1'b0; b_rd = 1'b0; b_we = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0;
        check_val("rnd_drain", fin, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
